// File: rtl/mc_maindec.sv
// mc_maindec -- multicycle main controller for the MIPS datapath.
// Steps each instruction through FETCH/DECODE/execute/memory/writeback
// states and drives the datapath controls for the current state.
// The opcode is captured in DECODE, so later states ignore changes on op.
// Parameters:
//   EXT_OPS  : 1 decodes ANDI/ORI/SLTI/BNE/JAL, 0 flags them illegal
//   MEM_WAIT : 1 stalls FETCH/MEMRD/MEMWR on mem_ready, 0 never stalls
// Ports:
//   clk, rst              : clock, async active-high reset
//   op[5:0]               : opcode field of the instruction register
//   mem_ready             : memory finishes the current access this cycle
//   mem_req, iord         : memory access active / address select
//   memwrite, irwrite, pcwrite, regwrite, branch, branchne : write enables
//   regdst, memtoreg, alusrca, zeroext, link : datapath mux selects
//   alusrcb[1:0], pcsrc[1:0], aluop[2:0]     : ALU / PC selects
//   illegal               : one-cycle pulse in DECODE on unsupported op
//   state[3:0]            : current state encoding (debug)
module mc_maindec #(
  parameter bit EXT_OPS  = 1'b1,
  parameter bit MEM_WAIT = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       pcwrite,
  output logic       regwrite,
  output logic       branch,
  output logic       branchne,
  output logic       regdst,
  output logic       memtoreg,
  output logic       alusrca,
  output logic       zeroext,
  output logic       link,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] aluop,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_IMMEX   = 4'd9,
    S_IMMWB   = 4'd10,
    S_JUMP    = 4'd11,
    S_JAL     = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  typedef struct packed {
    logic       mem_req;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       pcwrite;
    logic       regwrite;
    logic       branch;
    logic       branchne;
    logic       regdst;
    logic       memtoreg;
    logic       alusrca;
    logic       zeroext;
    logic       link;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] aluop;
    logic       illegal;
  } ctl_t;

  state_t     state_q, nxt;
  logic [5:0] op_q;
  ctl_t       c, c_o;
  logic       rdy;
  logic       dec_ok;
  state_t     dec_nxt;

  // With MEM_WAIT=0 every memory access completes in its first cycle.
  assign rdy = MEM_WAIT ? mem_ready : 1'b1;

  // Opcode decode for the DECODE state; extended ops are rejected when
  // EXT_OPS is off.
  always_comb begin
    dec_ok  = 1'b1;
    dec_nxt = S_FETCH;
    case (op)
      OP_RTYPE:                      dec_nxt = S_RTYPEEX;
      OP_LW, OP_SW:                  dec_nxt = S_MEMADR;
      OP_BEQ:                        dec_nxt = S_BRANCH;
      OP_ADDI:                       dec_nxt = S_IMMEX;
      OP_J:                          dec_nxt = S_JUMP;
      OP_BNE:                        begin dec_nxt = S_BRANCH; dec_ok = EXT_OPS; end
      OP_ANDI, OP_ORI, OP_SLTI:      begin dec_nxt = S_IMMEX;  dec_ok = EXT_OPS; end
      OP_JAL:                        begin dec_nxt = S_JAL;    dec_ok = EXT_OPS; end
      default:                       dec_ok  = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      op_q    <= '0;
    end else begin
      state_q <= nxt;
      if (state_q == S_DECODE) op_q <= op;
    end
  end

  always_comb begin
    c   = '0;
    nxt = state_q;
    case (state_q)
      S_FETCH: begin
        c.mem_req = 1'b1;
        c.alusrcb = 2'b01;
        c.irwrite = rdy;
        c.pcwrite = rdy;
        if (rdy) nxt = S_DECODE;
      end
      S_DECODE: begin
        c.alusrcb = 2'b11;
        if (dec_ok) nxt = dec_nxt;
        else begin
          c.illegal = 1'b1;
          nxt       = S_FETCH;
        end
      end
      S_MEMADR: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
        nxt       = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        c.mem_req = 1'b1;
        c.iord    = 1'b1;
        if (rdy) nxt = S_MEMWB;
      end
      S_MEMWB: begin
        c.regwrite = 1'b1;
        c.memtoreg = 1'b1;
        nxt        = S_FETCH;
      end
      S_MEMWR: begin
        c.mem_req  = 1'b1;
        c.iord     = 1'b1;
        c.memwrite = 1'b1;
        if (rdy) nxt = S_FETCH;
      end
      S_RTYPEEX: begin
        c.alusrca = 1'b1;
        c.aluop   = 3'b010;
        nxt       = S_ALUWB;
      end
      S_ALUWB: begin
        c.regwrite = 1'b1;
        c.regdst   = 1'b1;
        nxt        = S_FETCH;
      end
      S_BRANCH: begin
        c.alusrca  = 1'b1;
        c.aluop    = 3'b001;
        c.pcsrc    = 2'b01;
        c.branch   = (op_q == OP_BEQ);
        c.branchne = (op_q == OP_BNE);
        nxt        = S_FETCH;
      end
      S_IMMEX: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
        case (op_q)
          OP_ANDI: begin c.aluop = 3'b011; c.zeroext = 1'b1; end
          OP_ORI:  begin c.aluop = 3'b100; c.zeroext = 1'b1; end
          OP_SLTI: c.aluop = 3'b101;
          default: c.aluop = 3'b000;
        endcase
        nxt = S_IMMWB;
      end
      S_IMMWB: begin
        c.regwrite = 1'b1;
        nxt        = S_FETCH;
      end
      S_JUMP: begin
        c.pcsrc   = 2'b10;
        c.pcwrite = 1'b1;
        nxt       = S_FETCH;
      end
      S_JAL: begin
        c.pcsrc    = 2'b10;
        c.pcwrite  = 1'b1;
        c.regwrite = 1'b1;
        c.link     = 1'b1;
        nxt        = S_FETCH;
      end
      default: nxt = S_FETCH;  // unused encodings recover with outputs idle
    endcase
  end

  // Reset masks the outputs directly so nothing fires while rst is high,
  // even though FETCH would otherwise request memory.
  assign c_o      = rst ? '0 : c;
  assign state    = rst ? 4'd0 : state_q;
  assign mem_req  = c_o.mem_req;
  assign iord     = c_o.iord;
  assign memwrite = c_o.memwrite;
  assign irwrite  = c_o.irwrite;
  assign pcwrite  = c_o.pcwrite;
  assign regwrite = c_o.regwrite;
  assign branch   = c_o.branch;
  assign branchne = c_o.branchne;
  assign regdst   = c_o.regdst;
  assign memtoreg = c_o.memtoreg;
  assign alusrca  = c_o.alusrca;
  assign zeroext  = c_o.zeroext;
  assign link     = c_o.link;
  assign alusrcb  = c_o.alusrcb;
  assign pcsrc    = c_o.pcsrc;
  assign aluop    = c_o.aluop;
  assign illegal  = c_o.illegal;

endmodule

// File: tb/tb_mc_maindec.sv
// Bench for mc_maindec: instance 0 has EXT_OPS=1/MEM_WAIT=1, instance 1
// has EXT_OPS=0/MEM_WAIT=0. Expected per-cycle control vectors are queued
// as stimulus is driven and compared on the following falling edge.
module tb_mc_maindec;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] op;
  logic       mem_ready;

  logic [1:0]      mem_req, iord, memwrite, irwrite, pcwrite, regwrite;
  logic [1:0]      branch, branchne, regdst, memtoreg, alusrca, zeroext, link, illegal;
  logic [1:0][1:0] alusrcb, pcsrc;
  logic [1:0][2:0] aluop;
  logic [1:0][3:0] st;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mc_maindec #(.EXT_OPS(1'b1), .MEM_WAIT(1'b1)) dut0 (
    .clk(clk), .rst(rst), .op(op), .mem_ready(mem_ready),
    .mem_req(mem_req[0]), .iord(iord[0]), .memwrite(memwrite[0]),
    .irwrite(irwrite[0]), .pcwrite(pcwrite[0]), .regwrite(regwrite[0]),
    .branch(branch[0]), .branchne(branchne[0]), .regdst(regdst[0]),
    .memtoreg(memtoreg[0]), .alusrca(alusrca[0]), .zeroext(zeroext[0]),
    .link(link[0]), .alusrcb(alusrcb[0]), .pcsrc(pcsrc[0]), .aluop(aluop[0]),
    .illegal(illegal[0]), .state(st[0])
  );

  mc_maindec #(.EXT_OPS(1'b0), .MEM_WAIT(1'b0)) dut1 (
    .clk(clk), .rst(rst), .op(op), .mem_ready(mem_ready),
    .mem_req(mem_req[1]), .iord(iord[1]), .memwrite(memwrite[1]),
    .irwrite(irwrite[1]), .pcwrite(pcwrite[1]), .regwrite(regwrite[1]),
    .branch(branch[1]), .branchne(branchne[1]), .regdst(regdst[1]),
    .memtoreg(memtoreg[1]), .alusrca(alusrca[1]), .zeroext(zeroext[1]),
    .link(link[1]), .alusrcb(alusrcb[1]), .pcsrc(pcsrc[1]), .aluop(aluop[1]),
    .illegal(illegal[1]), .state(st[1])
  );

  // control vector bit positions
  localparam logic [24:0] MREQ = 25'h1 << 24;
  localparam logic [24:0] IORD = 25'h1 << 23;
  localparam logic [24:0] MW   = 25'h1 << 22;
  localparam logic [24:0] IRW  = 25'h1 << 21;
  localparam logic [24:0] PCW  = 25'h1 << 20;
  localparam logic [24:0] RW   = 25'h1 << 19;
  localparam logic [24:0] BR   = 25'h1 << 18;
  localparam logic [24:0] BRNE = 25'h1 << 17;
  localparam logic [24:0] RD   = 25'h1 << 16;
  localparam logic [24:0] MTR  = 25'h1 << 15;
  localparam logic [24:0] ALUA = 25'h1 << 14;
  localparam logic [24:0] ZE   = 25'h1 << 13;
  localparam logic [24:0] LNK  = 25'h1 << 12;
  localparam logic [24:0] ILL  = 25'h1 << 4;

  function automatic logic [24:0] fb(input int v); return 25'(v) << 10; endfunction
  function automatic logic [24:0] fp(input int v); return 25'(v) << 8;  endfunction
  function automatic logic [24:0] fa(input int v); return 25'(v) << 5;  endfunction
  function automatic logic [24:0] fs(input int v); return 25'(v);       endfunction

  localparam logic [5:0] RT = 6'b000000, LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] BEQ = 6'b000100, BNE = 6'b000101, ADDI = 6'b001000;
  localparam logic [5:0] ANDI = 6'b001100, ORI = 6'b001101, SLTI = 6'b001010;
  localparam logic [5:0] J = 6'b000010, JAL = 6'b000011, XOP = 6'b111111;

  function automatic logic [24:0] obs_of(input int i);
    return {mem_req[i], iord[i], memwrite[i], irwrite[i], pcwrite[i], regwrite[i],
            branch[i], branchne[i], regdst[i], memtoreg[i], alusrca[i], zeroext[i],
            link[i], alusrcb[i], pcsrc[i], aluop[i], illegal[i], st[i]};
  endfunction

  task automatic chk(input string tag, input logic [24:0] got, input logic [24:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [24:0] v;
    int          sel;
    string       tag;
  } exp_t;

  exp_t q[$];

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk(e.tag, obs_of(e.sel), e.v);
    end
  end

  // one clock cycle of stimulus with its expected control vector
  task automatic cyc(input logic [5:0] o, input logic r, input logic [24:0] e,
                     input int s, input string tag);
    op        = o;
    mem_ready = r;
    q.push_back('{v: e, sel: s, tag: tag});
    @(posedge clk); #1;
  endtask

  // memory-waiting state: w not-ready cycles then the ready cycle;
  // instance 1 ignores mem_ready and always takes one cycle
  task automatic memst(input logic [5:0] o, input int w, input int s,
                       input logic [24:0] base, input logic [24:0] rdyx, input string tag);
    if (s == 0) begin
      for (int i = 0; i < w; i++) cyc(o, 1'b0, base, s, tag);
      cyc(o, 1'b1, base | rdyx, s, tag);
    end else begin
      cyc(o, (w == 0), base | rdyx, s, tag);
    end
  endtask

  function automatic bit is_ext(input logic [5:0] o);
    return o inside {BNE, ANDI, ORI, SLTI, JAL};
  endfunction

  // one instruction: fw fetch waits, mw memory waits; op goes to garbage
  // after DECODE so only the latched opcode can steer the rest
  task automatic run(input logic [5:0] o, input int fw, input int mw,
                     input int s, input string nm);
    bit ill;
    memst(o, fw, s, MREQ | fb(1), IRW | PCW | fs(0), {nm, ".fetch"});
    ill = !(o inside {RT, LW, SW, BEQ, ADDI, J} || is_ext(o)) || (s == 1 && is_ext(o));
    cyc(o, 1'b1, fb(3) | fs(1) | (ill ? ILL : 25'h0), s, {nm, ".decode"});
    if (ill) return;
    case (o)
      LW: begin
        cyc(XOP, 1'b1, ALUA | fb(2) | fs(2), s, {nm, ".memadr"});
        memst(XOP, mw, s, MREQ | IORD | fs(3), 25'h0, {nm, ".memrd"});
        cyc(XOP, 1'b1, RW | MTR | fs(4), s, {nm, ".memwb"});
      end
      SW: begin
        cyc(XOP, 1'b1, ALUA | fb(2) | fs(2), s, {nm, ".memadr"});
        memst(XOP, mw, s, MREQ | IORD | MW | fs(5), 25'h0, {nm, ".memwr"});
      end
      RT: begin
        cyc(XOP, 1'b1, ALUA | fa(2) | fs(6), s, {nm, ".rtex"});
        cyc(XOP, 1'b1, RW | RD | fs(7), s, {nm, ".aluwb"});
      end
      BEQ:  cyc(XOP, 1'b1, ALUA | fa(1) | fp(1) | BR | fs(8), s, {nm, ".branch"});
      BNE:  cyc(XOP, 1'b1, ALUA | fa(1) | fp(1) | BRNE | fs(8), s, {nm, ".branch"});
      ADDI, ANDI, ORI, SLTI: begin
        logic [24:0] x;
        x = (o == ANDI) ? (fa(3) | ZE) : (o == ORI) ? (fa(4) | ZE) :
            (o == SLTI) ? fa(5) : fa(0);
        cyc(XOP, 1'b1, ALUA | fb(2) | x | fs(9), s, {nm, ".immex"});
        cyc(XOP, 1'b1, RW | fs(10), s, {nm, ".immwb"});
      end
      J:    cyc(XOP, 1'b1, fp(2) | PCW | fs(11), s, {nm, ".jump"});
      JAL:  cyc(XOP, 1'b1, fp(2) | PCW | RW | LNK | fs(12), s, {nm, ".jal"});
      default: ;
    endcase
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; op = RT; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.dut0", obs_of(0), 25'h0);
    chk("reset.dut1", obs_of(1), 25'h0);
    rst = 1'b0;

    // instance 0: full decode, honours mem_ready
    run(LW,   0, 0, 0, "lw");
    run(SW,   0, 3, 0, "sw_wait3");
    run(RT,   0, 0, 0, "rtype");
    run(BEQ,  0, 0, 0, "beq");
    run(BNE,  0, 0, 0, "bne");
    run(ORI,  0, 0, 0, "ori");
    run(JAL,  0, 0, 0, "jal");
    run(ANDI, 2, 0, 0, "andi_fwait2");
    run(SLTI, 0, 0, 0, "slti");
    run(ADDI, 0, 0, 0, "addi");
    run(J,    0, 0, 0, "j");
    run(LW,   1, 2, 0, "lw_wait");
    run(XOP,  0, 0, 0, "illegal");

    // asynchronous reset while MEMWR is asserting memwrite
    cyc(SW,  1'b1, MREQ | fb(1) | IRW | PCW | fs(0), 0, "ar.fetch");
    cyc(SW,  1'b1, fb(3) | fs(1), 0, "ar.decode");
    cyc(XOP, 1'b1, ALUA | fb(2) | fs(2), 0, "ar.memadr");
    mem_ready = 1'b0;
    #1 chk("ar.memwr", obs_of(0), MREQ | IORD | MW | fs(5));
    rst = 1'b1;
    #1 chk("ar.async", obs_of(0), 25'h0);
    mem_ready = 1'b1;
    @(posedge clk); #1;
    chk("ar.held", obs_of(0), 25'h0);
    rst = 1'b0;
    run(LW, 0, 0, 0, "ar.after");

    // instance 1: no extended ops, mem_ready ignored
    rst = 1'b1;
    @(posedge clk); #1;
    chk("reset2.dut1", obs_of(1), 25'h0);
    rst = 1'b0;
    run(LW,   2, 2, 1, "nw.lw");
    run(SW,   1, 3, 1, "nw.sw");
    run(BNE,  0, 0, 1, "nx.bne");
    run(JAL,  0, 0, 1, "nx.jal");
    run(ORI,  0, 0, 1, "nx.ori");
    run(BEQ,  0, 0, 1, "nx.beq");
    run(ADDI, 1, 0, 1, "nx.addi");

    @(negedge clk); #1;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard leftover=%0d", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mc_maindec.md
# mc_maindec

Multicycle main controller for the MIPS datapath: a parametrised successor to the single-cycle opcode decoder. Walks each instruction through fetch, decode, execute, memory and writeback states, emitting per-state datapath controls. Stalls on a memory ready handshake. Optionally supports extended opcodes (ANDI, ORI, SLTI, BNE, JAL). Sits between the instruction register opcode field and the multicycle datapath / unified memory port.

## Interface
- EXT_OPS, 1, 1 enables ANDI/ORI/SLTI/BNE/JAL decode; 0 treats them as illegal
- MEM_WAIT, 1, 1 honours mem_ready; 0 treats mem_ready as constant 1
- clk  in  1  clock, all state changes on rising edge
- rst  in  1  reset, asynchronous, active-high
- op  in  6  instruction[31:26] from instruction register
- mem_ready  in  1  memory completes current access this cycle
- mem_req  out  1  memory access active
- iord  out  1  0 = PC address, 1 = ALUOut address
- memwrite, irwrite, pcwrite, regwrite  out  1 each  write enables
- branch, branchne  out  1 each  conditional PC write on zero / not-zero
- regdst, memtoreg, alusrca, zeroext, link  out  1 each  datapath muxes (link selects $31 and PC+4 as write data)
- alusrcb  out  2  00 rt, 01 const 4, 10 imm, 11 imm<<2
- pcsrc  out  2  00 ALU result, 01 ALUOut, 10 jump target
- aluop  out  3  000 add, 001 sub, 010 funct field, 011 and, 100 or, 101 slt
- illegal  out  1  one-cycle pulse on unsupported opcode
- state  out  4  current state encoding (debug)

## Operation
- States (encoding): FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTYPEEX 6, ALUWB 7, BRANCH 8, IMMEX 9, IMMWB 10, JUMP 11, JAL 12. Encodings 13-15 return to FETCH next cycle with all outputs 0.
- Outputs are combinational from state (and mem_ready where noted). Every output not listed for a state is 0.
- FETCH: mem_req=1, alusrcb=01, aluop=000. irwrite=pcwrite=mem_ready. Advance to DECODE when mem_ready, else hold.
- DECODE: alusrcb=11, aluop=000. Latch op into internal op_q. Next state by op:
  - 000000 → RTYPEEX
  - 100011/101011 → MEMADR
  - 000100 → BRANCH
  - 001000 → IMMEX
  - 000010 → JUMP
  - if EXT_OPS: 000101 → BRANCH; 001100/001101/001010 → IMMEX; 000011 → JAL
  - otherwise illegal=1 for this cycle, next FETCH
- MEMADR: alusrca=1, alusrcb=10, aluop=000. Next MEMRD if op_q=LW, else MEMWR.
- MEMRD: mem_req=1, iord=1. Hold until mem_ready, then MEMWB.
- MEMWB: regwrite=1, memtoreg=1. Next FETCH.
- MEMWR: mem_req=1, iord=1, memwrite=1 for whole state. Hold until mem_ready, then FETCH.
- RTYPEEX: alusrca=1, aluop=010. Next ALUWB.
- ALUWB: regwrite=1, regdst=1. Next FETCH.
- BRANCH: alusrca=1, aluop=001, pcsrc=01. branch=1 for BEQ, branchne=1 for BNE. Next FETCH.
- IMMEX: alusrca=1, alusrcb=10. aluop: ADDI 000, ANDI 011, ORI 100, SLTI 101. zeroext=1 for ANDI/ORI. Next IMMWB.
- IMMWB: regwrite=1. Next FETCH.
- JUMP: pcsrc=10, pcwrite=1. Next FETCH.
- JAL: pcsrc=10, pcwrite=1, regwrite=1, link=1. Next FETCH.
- With MEM_WAIT=0: FETCH, MEMRD and MEMWR each last exactly one cycle.

## Timing
- Reset: state=FETCH and op_q=0 immediately on rst rising. While rst=1, every output is forced 0, including mem_req and irwrite, regardless of mem_ready.
- First mem_req appears in the first cycle after rst deasserts.
- Reset mid-instruction aborts it. No write enable is asserted in the reset cycle.
- Latency with zero wait states, cycles from FETCH entry to next FETCH entry:
  - LW 5; SW 4; R-type 4; ADDI/ANDI/ORI/SLTI 4; BEQ/BNE 3; J/JAL 3.
- Each wait cycle (mem_ready=0 in FETCH, MEMRD or MEMWR) adds exactly one cycle.
- op changes after DECODE have no effect; only op_q steers later states.
- illegal is never asserted outside DECODE.

## Test plan
- Reset mid-MEMWR (rst pulse while memwrite=1) → outputs 0 asynchronously; state=0; after release, mem_req=1, iord=0.
- LW, mem_ready tied 1 → state sequence 0,1,2,3,4,0. regwrite=memtoreg=1 only in state 4.
- SW with mem_ready low for 3 cycles in MEMWR → memwrite held 4 cycles; FETCH follows the ready cycle; regwrite never 1.
- BNE (000101), EXT_OPS=1 → state 8, branchne=1, aluop=001, pcsrc=01. With EXT_OPS=0 → illegal pulses once in state 1, then state 0.
- ORI then JAL, EXT_OPS=1 → IMMEX shows aluop=100, zeroext=1. JAL state shows pcwrite=regwrite=link=1, pcsrc=10.
- FETCH with mem_ready low 2 cycles, MEM_WAIT=1 → irwrite/pcwrite 0 for 2 cycles, then 1 for one cycle. Same stimulus with MEM_WAIT=0 → DECODE entered after 1 cycle.
